// File: rtl/xbar_req_stimulus_if.sv
// rtl/xbar_req_stimulus_if.sv - per-port req/dest/ack handshake bundle for the crossbar stimulus
interface xbar_req_stimulus_if #(
  parameter int N_PORTS = 4,
  parameter int DEST_W  = $clog2(N_PORTS)
);
  logic [N_PORTS-1:0]        req;
  logic [N_PORTS*DEST_W-1:0] dest;
  logic [N_PORTS-1:0]        ack;

  modport master (output req, output dest, input ack);
  modport slave  (input req, input dest, output ack);
endinterface

// File: rtl/xbar_req_stimulus.sv
// rtl/xbar_req_stimulus.sv - N-port crossbar request-traffic generator; XBAR_STIM_TIMEOUT_EN adds per-port ack timeout
module xbar_req_stimulus #(
  parameter int          N_PORTS    = 4,
  parameter int          DEST_W     = $clog2(N_PORTS),
  parameter int          GAP_CYCLES = 2,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          CNT_W      = 16,
  parameter int          TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 hard_reset,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [N_PORTS-1:0]   pattern,
  xbar_req_stimulus_if.master  bus,
  output logic [CNT_W-1:0]     grant_cnt,
  output logic [N_PORTS-1:0]   timeout_flag
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [15:0]     SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  state_t                    state_q [N_PORTS];
  state_t                    state_d [N_PORTS];
  logic [GAP_W-1:0]          gap_q   [N_PORTS];
  logic [GAP_W-1:0]          gap_d   [N_PORTS];
  logic [N_PORTS*DEST_W-1:0] dest_q, dest_d;
  logic [N_PORTS-1:0]        req_q, req_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [DEST_W-1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [N_PORTS-1:0]        accepted;
  logic [N_PORTS-1:0]        timed_out;
  logic [N_PORTS-1:0]        issue;

  // An ack only counts while the port actually has a request outstanding.
  always_comb begin
    accepted = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      accepted[i] = bus.ack[i] && (state_q[i] == S_REQ);
    end
  end

`ifdef XBAR_STIM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0]  wait_q [N_PORTS];
  logic [WAIT_W-1:0]  wait_d [N_PORTS];
  logic [N_PORTS-1:0] tflag_q, tflag_d;

  // Ack in the final wait cycle takes priority over the timeout.
  always_comb begin
    timed_out = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      timed_out[i] = (state_q[i] == S_REQ) && !bus.ack[i] &&
                     (wait_q[i] == WAIT_W'(TIMEOUT - 1));
      wait_d[i]    = ((state_q[i] == S_REQ) && !accepted[i] && !timed_out[i]) ?
                     wait_q[i] + 1'b1 : '0;
    end
    tflag_d = tflag_q | timed_out;
  end

  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        wait_q[i] <= '0;
      end
      tflag_q <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        wait_q[i] <= wait_d[i];
      end
      tflag_q <= tflag_d;
    end
  end

  assign timeout_flag = tflag_q;
`else
  assign timed_out    = '0;
  assign timeout_flag = '0;
`endif

  always_comb begin
    lfsr_d = en ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]} : lfsr_q;
    ptr_d  = ptr_q;
    if ((mode == 2'd0) && accepted[ptr_q]) begin
      ptr_d = ptr_q + DEST_W'(1);
    end
    cnt_d  = cnt_q;
    dest_d = dest_q;
    issue  = '0;
    req_d  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      state_d[i] = state_q[i];
      gap_d[i]   = gap_q[i];
      cnt_d      = cnt_d + CNT_W'(accepted[i]);
      case (mode)
        2'd0:    issue[i] = (ptr_q == DEST_W'(i));
        2'd1:    issue[i] = 1'b1;
        2'd2:    issue[i] = lfsr_q[i % 16];
        default: issue[i] = pattern[i];
      endcase
      case (state_q[i])
        S_IDLE: begin
          if (en && issue[i]) begin
            state_d[i] = S_REQ;
            // Power-of-two port count: DEST_W truncation is the modulo.
            dest_d[i*DEST_W +: DEST_W] = DEST_W'(i + 1) +
                                         ((mode == 2'd2) ? lfsr_q[DEST_W-1:0] : '0);
          end
        end
        S_REQ: begin
          if (accepted[i] || timed_out[i]) begin
            state_d[i] = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            gap_d[i]   = '0;
          end
        end
        S_GAP: begin
          if (gap_q[i] == GAP_LAST) begin
            state_d[i] = S_IDLE;
          end else begin
            gap_d[i] = gap_q[i] + 1'b1;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
      req_d[i] = (state_d[i] == S_REQ);
    end
  end

  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        state_q[i] <= S_IDLE;
        gap_q[i]   <= '0;
      end
      dest_q <= '0;
      req_q  <= '0;
      lfsr_q <= SEED_EFF;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        state_q[i] <= state_d[i];
        gap_q[i]   <= gap_d[i];
      end
      dest_q <= dest_d;
      req_q  <= req_d;
      lfsr_q <= lfsr_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.req   = req_q;
  assign bus.dest  = dest_q;
  assign grant_cnt = cnt_q;
endmodule

// File: doc/xbar_req_stimulus.md
Name: xbar_req_stimulus

Overview:
- Parametrised request-traffic generator for an N-port crossbar switch.
- Drives per-port req/dest and honours a per-port req/ack handshake. Supports four traffic modes: walking, saturate, LFSR random and fixed pattern.
- Used as the synthesizable stimulus source in crossbar benches and FPGA bring-up.
- Generalises the fixed 4-port stimulus to N_PORTS, adds destination generation, inter-request gap control and grant counting.

Parameters:
- N_PORTS, 4, port count; power of two, >=2.
- DEST_W, $clog2(N_PORTS), destination index width.
- GAP_CYCLES, 2, extra idle cycles after each grant (0 allowed).
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.
- CNT_W, 16, grant counter width.
- TIMEOUT, 64, ack wait limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- hard_reset  in  1  asynchronous, active-low reset.
- en  in  1  permits new requests to issue.
- mode  in  2  0=walking, 1=saturate, 2=random, 3=pattern.
- pattern  in  N_PORTS  port request mask used in mode 3.
- ack  in  N_PORTS  per-port grant from the crossbar.
- req  out  N_PORTS  per-port request, registered.
- dest  out  N_PORTS*DEST_W  per-port destination; port i occupies slice [i*DEST_W +: DEST_W].
- grant_cnt  out  CNT_W  total accepted acks.
- timeout_flag  out  N_PORTS  sticky per-port timeout indicator.

Behaviour:
- Reset (hard_reset=0, asynchronous):
  - req=0, dest=0, grant_cnt=0, timeout_flag=0.
  - LFSR=SEED, walk pointer ptr=0, every port FSM in IDLE.
  - Assertion mid-handshake drops req immediately, with no wait for ack.
- LFSR:
  - 16-bit Fibonacci, x^16+x^14+x^13+x^11+1.
  - Shifts every cycle while en=1; holds while en=0.
- Per-port FSM states: IDLE, REQ, GAP.
- IDLE -> REQ:
  - Transition occurs when en=1 and the mode's issue condition holds.
  - req[i]=1 and dest latched on the next edge (1-cycle latency).
- Issue conditions:
  - Mode 0: i==ptr.
  - Mode 1: always.
  - Mode 2: LFSR bit (i mod 16) = 1.
  - Mode 3: pattern[i] = 1.
- Destination:
  - Modes 0, 1, 3: dest_i = (i+1) mod N_PORTS.
  - Mode 2: dest_i = (i + 1 + LFSR[DEST_W-1:0]) mod N_PORTS, truncated; self-destination is allowed.
- REQ:
  - req and dest are held stable until ack[i] is sampled high.
  - en=0 and mode changes do not affect an outstanding request.
- REQ -> GAP on ack:
  - req falls on the next edge.
  - GAP lasts GAP_CYCLES cycles, then IDLE for one cycle before the next issue.
  - Minimum low time is therefore GAP_CYCLES+1 cycles. With GAP_CYCLES=0, GAP is skipped and the FSM goes straight to IDLE.
- ack[i] sampled while port i is in IDLE or GAP is ignored.
- Walk pointer: ptr increments, wrapping N_PORTS-1 -> 0, on ack of port ptr while in mode 0. It is frozen in the other modes.
- grant_cnt:
  - Adds the popcount of accepted acks each cycle; simultaneous acks all count.
  - Wraps modulo 2^CNT_W and is cleared only by reset.

Optional Feature:
- Macro: XBAR_STIM_TIMEOUT_EN.
- Defined:
  - Per-port wait counter runs while in REQ.
  - After TIMEOUT cycles without ack, req drops, the port enters GAP and timeout_flag[i] is set; the flag stays set until reset.
  - ack in the same cycle as timeout: ack wins, the grant is counted and no flag is set.
  - A timed-out request does not advance ptr.
- Undefined: no counters are built, timeout_flag is tied to 0 and requests wait indefinitely.

Test Plan:
- Reset release, mode=1, en=1, ack=0 -> req=4'b1111 one cycle after the first en edge; dest = {0,3,2,1} (port3..port0); grant_cnt=0.
- Mode 1, GAP_CYCLES=2, ack[0] high in cycle k only:
  - req[0] low in cycles k+1..k+3, high again from k+4.
  - grant_cnt increments by 1.
- Mode 0, ack each request immediately:
  - req walks 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - Only one bit is ever set at a time.
- Simultaneous ack=4'b1111 in mode 1 -> grant_cnt increases by 4 in one cycle. Separately, drive grant_cnt to 2^CNT_W-1 and apply one ack -> grant_cnt wraps to 0.
- hard_reset pulsed low while req=1111 -> req=0 asynchronously, before the next clk edge; LFSR sequence repeats from SEED after release.
- XBAR_STIM_TIMEOUT_EN, TIMEOUT=64, ack[2] never asserted:
  - req[2] drops after 64 cycles and timeout_flag=4'b0100.
  - Repeat with ack[2] arriving in the 64th cycle -> flag stays 0.
